// File: rtl/keypad_event_ctrl_if.sv
// Event handshake between the keypad sequencer (master) and the control FSM (slave).
interface keypad_event_ctrl_if;
   logic       evt_valid;
   logic       evt_ready;
   logic [3:0] evt_code;
   logic       evt_rpt;

   modport master (output evt_valid, output evt_code, output evt_rpt, input evt_ready);
   modport slave  (input evt_valid, input evt_code, input evt_rpt, output evt_ready);
endinterface

// File: rtl/keypad_event_ctrl.sv
// Keypad sequencer: tick-sampled debounce, press-to-event scan, show-ahead event FIFO.
// Optional auto-repeat of a single held key is built when KEY_REPEAT_EN is defined.
module keypad_event_ctrl #(
   parameter int SAMPLE_DIV   = 20000,
   parameter int DEBOUNCE_N   = 4,
   parameter int FIFO_DEPTH   = 4,
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 10
) (
   input  logic                       clkin,
   input  logic                       rst,
   input  logic [15:0]                keys,
   keypad_event_ctrl_if.master        evt,
   output logic [15:0]                key_state,
   output logic                       ovf,
   input  logic                       ovf_clr
);

   localparam int TW = $clog2(SAMPLE_DIV);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
   localparam logic [3:0]    DEB_N     = 4'(DEBOUNCE_N);
   localparam logic [4:0]    DEB_N5    = 5'(DEBOUNCE_N);
`ifdef KEY_REPEAT_EN
   localparam int EW = 5;
   localparam int RW = $clog2(REPEAT_DELAY + 1);
   localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE);
`else
   localparam int EW = 4;
`endif

   if (SAMPLE_DIV < 20 || DEBOUNCE_N < 1 || DEBOUNCE_N > 15 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_RATE < 1 || REPEAT_DELAY < REPEAT_RATE)
   begin : g_param_check
      $error("keypad_event_ctrl: illegal parameter set");
   end

   typedef enum logic [1:0] {S_WAIT, S_FILTER, S_SCAN} state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
   logic            tick;
   logic [15:0]     cand_q, cand_d;
   logic [15:0]     key_state_q, key_state_d;
   logic [15:0]     pend_q, pend_d;
   logic [3:0]      stable_cnt_q, stable_cnt_d;
   logic [4:0]      stable_inc;
   logic [3:0]      idx_q, idx_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic            ovf_q, ovf_d;
   logic            push_req, push, pop, drop;
   logic            fifo_empty, fifo_full;
   logic [3:0]      push_code;
   logic [EW-1:0]   push_data;
   logic [EW-1:0]   head;
   logic [EW-1:0]   mem [FIFO_DEPTH];
`ifdef KEY_REPEAT_EN
   logic            push_rpt;
   logic [RW-1:0]   rpt_cnt_q, rpt_cnt_d;
   logic [RW-1:0]   rpt_inc;
   logic [3:0]      rpt_key;
`endif

   always_comb begin
      tick         = (tick_cnt_q == TICK_LAST);
      tick_cnt_d   = tick ? '0 : tick_cnt_q + TW'(1);
      state_d      = state_q;
      cand_d       = cand_q;
      key_state_d  = key_state_q;
      pend_d       = pend_q;
      idx_d        = idx_q;
      stable_cnt_d = stable_cnt_q;
      stable_inc   = {1'b0, stable_cnt_q} + 5'd1;
      push_req     = 1'b0;
      push_code    = idx_q;

      case (state_q)
         S_WAIT: begin
            if (tick) state_d = S_FILTER;
         end
         S_FILTER: begin
            state_d = S_WAIT;
            if (keys != cand_q) begin
               cand_d       = keys;
               stable_cnt_d = 4'd1;
            end else begin
               stable_cnt_d = (stable_inc >= DEB_N5) ? DEB_N : stable_inc[3:0];
               if (stable_inc == DEB_N5 && cand_q != key_state_q) begin
                  key_state_d = cand_q;
                  pend_d      = cand_q & ~key_state_q;
                  idx_d       = 4'd0;
                  state_d     = S_SCAN;
               end
            end
         end
         S_SCAN: begin
            // One index per cycle keeps events in ascending key order.
            push_req = pend_q[idx_q];
            idx_d    = idx_q + 4'd1;
            if (idx_q == 4'd15) state_d = S_WAIT;
         end
         default: state_d = S_WAIT;
      endcase

`ifdef KEY_REPEAT_EN
      push_rpt  = 1'b0;
      rpt_cnt_d = rpt_cnt_q;
      rpt_inc   = rpt_cnt_q + RW'(1);
      rpt_key   = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (key_state_q[i]) rpt_key = 4'(i);
      end
      if (!$onehot(key_state_q) || key_state_d != key_state_q) begin
         rpt_cnt_d = '0;
      end else if (state_q == S_FILTER) begin
         // Reloading DELAY-RATE makes every later repeat land RATE ticks apart.
         if (rpt_inc == RPT_LAST) begin
            push_req  = 1'b1;
            push_rpt  = 1'b1;
            push_code = rpt_key;
            rpt_cnt_d = RPT_RELOAD;
         end else begin
            rpt_cnt_d = rpt_inc;
         end
      end
      push_data = {push_rpt, push_code};
`else
      push_data = push_code;
`endif

      fifo_empty = (wr_ptr_q == rd_ptr_q);
      fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop        = !fifo_empty && evt.evt_ready;
      push       = push_req && (!fifo_full || pop);
      drop       = push_req && fifo_full && !pop;
      wr_ptr_d   = wr_ptr_q + PW'(push);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      ovf_d      = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
   end

   always_ff @(posedge clkin) begin
      if (!rst) begin
         state_q      <= S_WAIT;
         tick_cnt_q   <= '0;
         cand_q       <= '0;
         key_state_q  <= '0;
         pend_q       <= '0;
         idx_q        <= '0;
         stable_cnt_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         ovf_q        <= 1'b0;
`ifdef KEY_REPEAT_EN
         rpt_cnt_q    <= '0;
`endif
      end else begin
         state_q      <= state_d;
         tick_cnt_q   <= tick_cnt_d;
         cand_q       <= cand_d;
         key_state_q  <= key_state_d;
         pend_q       <= pend_d;
         idx_q        <= idx_d;
         stable_cnt_q <= stable_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         ovf_q        <= ovf_d;
`ifdef KEY_REPEAT_EN
         rpt_cnt_q    <= rpt_cnt_d;
`endif
      end
   end

   always_ff @(posedge clkin) begin
      if (push) mem[wr_ptr_q[AW-1:0]] <= push_data;
   end

   // Empty FIFO shows zeros rather than stale storage.
   assign head          = mem[rd_ptr_q[AW-1:0]];
   assign evt.evt_valid = !fifo_empty;
   assign evt.evt_code  = fifo_empty ? 4'd0 : head[3:0];
`ifdef KEY_REPEAT_EN
   assign evt.evt_rpt   = fifo_empty ? 1'b0 : head[4];
`else
   assign evt.evt_rpt   = 1'b0;
`endif
   assign key_state     = key_state_q;
   assign ovf           = ovf_q;

endmodule
